// File: rtl/cnn_stream_pkg.sv
// Shared types and layer constants for the MNIST stream readers.
// Readers that walk a layer's output buffer import this package.
package cnn_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_SRC,
    ISSUE,
    WAIT_RD,
    CAPTURE,
    OUT,
    DONE
  } reader_state_e;

  localparam int POOL1_CH    = 32;
  localparam int POOL1_H     = 13;
  localparam int POOL1_W     = 13;
  localparam int POOL1_BYTES = POOL1_CH * POOL1_H * POOL1_W;

  // Counter width for a 0..bound-1 range; never collapses to zero bits.
  function automatic int cnt_w(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/fmap_index_counter.sv
// Channel/row/column walker with a matching linear element index.
// Raises ch_last on the final element of a channel and frame_last on the final element overall.
module fmap_index_counter
  import cnn_stream_pkg::*;
#(
  parameter int CHANNELS = POOL1_CH,
  parameter int HEIGHT   = POOL1_H,
  parameter int WIDTH    = POOL1_W,
  parameter int LIN_W    = cnt_w(CHANNELS * HEIGHT * WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             advance,
  output logic [LIN_W-1:0] lin,
  output logic             ch_last,
  output logic             frame_last
);

  localparam int CH_W  = cnt_w(CHANNELS);
  localparam int ROW_W = cnt_w(HEIGHT);
  localparam int COL_W = cnt_w(WIDTH);

  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CHANNELS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);

  logic [CH_W-1:0]  ch;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
      lin <= '0;
    end else if (clear) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
      lin <= '0;
    end else if (advance) begin
      lin <= lin + LIN_W'(1);
      if (col == COL_MAX) begin
        col <= '0;
        if (row == ROW_MAX) begin
          row <= '0;
          ch  <= (ch == CH_MAX) ? '0 : ch + CH_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign ch_last    = (row == ROW_MAX) && (col == COL_MAX);
  assign frame_last = ch_last && (ch == CH_MAX);

endmodule

// File: rtl/pool_fmap_stream_reader.sv
// Launches the pool layer, then streams its pooled feature map byte by byte in ch/row/col order.
// Stream handshake: a byte transfers on a rising clk edge where m_valid && m_ready; while m_valid is high and m_ready low, m_data/m_ch_last/m_last are held stable.
module pool_fmap_stream_reader
  import cnn_stream_pkg::*;
#(
  parameter int CHANNELS = POOL1_CH,
  parameter int HEIGHT   = POOL1_H,
  parameter int WIDTH    = POOL1_W,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              src_start,
  input  logic              src_done,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_ch_last,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output reader_state_e     dbg_state
);

  localparam int LIN_W = cnt_w(CHANNELS * HEIGHT * WIDTH);

  reader_state_e    state_q, state_d;
  logic             cnt_clear, cnt_advance, capture, handshake;
  logic [LIN_W-1:0] lin;
  logic             ch_last, frame_last;

  fmap_index_counter #(
    .CHANNELS (CHANNELS),
    .HEIGHT   (HEIGHT),
    .WIDTH    (WIDTH),
    .LIN_W    (LIN_W)
  ) u_index (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .lin        (lin),
    .ch_last    (ch_last),
    .frame_last (frame_last)
  );

  // The linear index is the byte address; it only moves on a handshake, so it stays fixed from ISSUE to CAPTURE.
  assign src_addr  = ADDR_W'(lin);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    src_start   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    m_valid     = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    capture     = 1'b0;
    handshake   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state_q == DONE);
        if (start) begin
          cnt_clear = 1'b1;
          // A source that already finished is re-read without being relaunched.
          state_d   = src_done ? ISSUE : LAUNCH;
        end
      end
      LAUNCH: begin
        src_start = 1'b1;
        state_d   = WAIT_SRC;
      end
      WAIT_SRC: if (src_done) state_d = ISSUE;
      ISSUE:    state_d = WAIT_RD;
      WAIT_RD:  state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          handshake = 1'b1;
          if (m_last) begin
            state_d = DONE;
          end else begin
            cnt_advance = 1'b1;
            state_d     = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_data    <= '0;
      m_ch_last <= 1'b0;
      m_last    <= 1'b0;
    end else if (capture) begin
      m_data    <= src_data;
      m_ch_last <= ch_last;
      m_last    <= frame_last;
    end else if (handshake) begin
      m_ch_last <= 1'b0;
      m_last    <= 1'b0;
    end
  end

endmodule
